// File: rtl/addsub_pkg.sv
// Shared types and defaults for the signed add/subtract accumulator.
package addsub_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CONV = 2'd2
    } addsub_state_t;

    localparam int DEFAULT_W = 4;
endpackage

// File: rtl/addsub_accum_if.sv
// Control, operand and result bundle between the display datapath and addsub_accum.
interface addsub_accum_if
    import addsub_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic         CLR;
    logic         ENTER;
    logic         SUB;
    logic         ACC;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] RES_MAG;
    logic         RES_NEG;
    logic         VALID;
    logic         OVF_STICKY;
    logic         BUSY;
    logic         DONE;

    modport master (
        output CLR, ENTER, SUB, ACC, A, B,
        input  RES_MAG, RES_NEG, VALID, OVF_STICKY, BUSY, DONE
    );

    modport slave (
        input  CLR, ENTER, SUB, ACC, A, B,
        output RES_MAG, RES_NEG, VALID, OVF_STICKY, BUSY, DONE
    );
endinterface

// File: rtl/addsub_accum_twos_to_signmag.sv
// Two's complement to sign-magnitude; the most-negative input maps to magnitude 2^(W-1) in W bits.
module twos_to_signmag #(
    parameter int W = 4
) (
    input  logic [W-1:0] sum,
    output logic [W-1:0] mag,
    output logic         neg
);
    // Negate only when negative; -(100..0) wraps back to 100..0, which reads as 2^(W-1) unsigned.
    always_comb begin
        neg = sum[W-1] & (sum != {W{1'b0}});
        if (neg) begin
            mag = -sum;
        end else begin
            mag = sum;
        end
    end
endmodule

// File: rtl/addsub_accum.sv
// Signed add/subtract with accumulate mode, sequenced IDLE -> EXEC -> CONV, sign-magnitude result.
module addsub_accum
    import addsub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           RST,
    addsub_accum_if.slave  bus
);
    addsub_state_t state_r, state_s;

    logic         enter_q_r;
    logic         start_s;
    logic [W-1:0] opa_r, opb_r, sum_r, acc_r, res_mag_r;
    logic [W-1:0] sum_s, mag_s;
    logic         cin_r, ovf_r, ovf_s, neg_s;
    logic         res_neg_r, valid_r, ovf_sticky_r, done_r;

    assign start_s = (state_r == IDLE) & bus.ENTER & ~enter_q_r;
    assign sum_s   = opa_r + opb_r + {{(W-1){1'b0}}, cin_r};
    assign ovf_s   = (opa_r[W-1] == opb_r[W-1]) & (sum_s[W-1] != opa_r[W-1]);

    twos_to_signmag #(.W(W)) u_conv (
        .sum (sum_r),
        .mag (mag_s),
        .neg (neg_s)
    );

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; CLR forces IDLE and drops any coincident start.
    always_comb begin
        state_s = state_r;
        if (bus.CLR) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = start_s ? EXEC : IDLE;
                EXEC:    state_s = CONV;
                CONV:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Edge history, operand capture, sum/overflow and result registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            enter_q_r    <= 1'b1;
            opa_r        <= {W{1'b0}};
            opb_r        <= {W{1'b0}};
            cin_r        <= 1'b0;
            sum_r        <= {W{1'b0}};
            ovf_r        <= 1'b0;
            acc_r        <= {W{1'b0}};
            res_mag_r    <= {W{1'b0}};
            res_neg_r    <= 1'b0;
            valid_r      <= 1'b1;
            ovf_sticky_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            enter_q_r <= bus.ENTER;
            if (bus.CLR) begin
                acc_r        <= {W{1'b0}};
                res_mag_r    <= {W{1'b0}};
                res_neg_r    <= 1'b0;
                valid_r      <= 1'b1;
                ovf_sticky_r <= 1'b0;
                done_r       <= 1'b0;
            end else begin
                done_r <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (start_s) begin
                            opa_r <= bus.ACC ? acc_r : bus.A;
                            opb_r <= bus.SUB ? ~bus.B : bus.B;
                            cin_r <= bus.SUB;
                        end
                    end
                    EXEC: begin
                        sum_r <= sum_s;
                        ovf_r <= ovf_s;
                    end
                    CONV: begin
                        // An overflowed op leaves the displayed value and the accumulator untouched.
                        if (!ovf_r) begin
                            res_mag_r <= mag_s;
                            res_neg_r <= neg_s;
                            acc_r     <= sum_r;
                            valid_r   <= 1'b1;
                        end else begin
                            valid_r      <= 1'b0;
                            ovf_sticky_r <= 1'b1;
                        end
                        done_r <= 1'b1;
                    end
                    default: begin
                        done_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.RES_MAG    = res_mag_r;
    assign bus.RES_NEG    = res_neg_r;
    assign bus.VALID      = valid_r;
    assign bus.OVF_STICKY = ovf_sticky_r;
    // BUSY spans the DONE cycle too, so the host sees one unbroken busy window per op.
    assign bus.BUSY       = (state_r != IDLE) | done_r;
    assign bus.DONE       = done_r;
endmodule

// File: tb/tb_addsub_accum.sv
// Self-checking bench for addsub_accum: integer reference model for W=4 plus directed literal checks at W=4 and W=8.
module tb_addsub_accum;
    import addsub_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    addsub_accum_if #(.W(4)) bus4 ();
    addsub_accum_if #(.W(8)) bus8 ();

    addsub_accum #(.W(4)) dut4 (.clk(clk), .RST(rst), .bus(bus4));
    addsub_accum #(.W(8)) dut8 (.clk(clk), .RST(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int calc(bit acc_mode, bit sub, int a, int b, int accv);
        int x;
        x = acc_mode ? accv : a;
        return sub ? (x - b) : (x + b);
    endfunction

    function automatic bit fits(int r, int w);
        return (r >= -(1 <<< (w - 1))) && (r <= (1 <<< (w - 1)) - 1);
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model for the W=4 instance: whole-number arithmetic, result lands two cycles after the start edge.
    int m_acc, m_mag, m_pend, m_cnt;
    bit m_neg, m_valid, m_sticky, m_done, m_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev <= 1'b1; m_cnt <= 0; m_acc <= 0; m_mag <= 0; m_pend <= 0;
            m_neg <= 1'b0; m_valid <= 1'b1; m_sticky <= 1'b0; m_done <= 1'b0;
        end else begin
            m_prev <= bus4.ENTER;
            if (bus4.CLR) begin
                m_cnt <= 0; m_acc <= 0; m_mag <= 0;
                m_neg <= 1'b0; m_valid <= 1'b1; m_sticky <= 1'b0; m_done <= 1'b0;
            end else begin
                m_done <= 1'b0;
                if (m_cnt == 0) begin
                    if (bus4.ENTER && !m_prev) begin
                        m_pend <= calc(bus4.ACC, bus4.SUB, int'($signed(bus4.A)),
                                       int'($signed(bus4.B)), m_acc);
                        m_cnt  <= 1;
                    end
                end else if (m_cnt == 1) begin
                    m_cnt <= 2;
                end else begin
                    m_cnt  <= 0;
                    m_done <= 1'b1;
                    if (fits(m_pend, 4)) begin
                        m_acc   <= m_pend;
                        m_mag   <= (m_pend < 0) ? -m_pend : m_pend;
                        m_neg   <= (m_pend < 0);
                        m_valid <= 1'b1;
                    end else begin
                        m_valid  <= 1'b0;
                        m_sticky <= 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the W=4 outputs against the model.
    always @(negedge clk) begin
        check("cyc_res_mag", int'(bus4.RES_MAG), m_mag);
        check("cyc_res_neg", int'(bus4.RES_NEG), int'(m_neg));
        check("cyc_valid", int'(bus4.VALID), int'(m_valid));
        check("cyc_ovf_sticky", int'(bus4.OVF_STICKY), int'(m_sticky));
        check("cyc_busy", int'(bus4.BUSY), int'((m_cnt != 0) || m_done));
        check("cyc_done", int'(bus4.DONE), int'(m_done));
    end

    task automatic op4(string name, int a, int b, bit sub, bit accm,
                       int e_mag, int e_neg, int e_valid, int e_sticky);
        int cyc;
        bus4.A = 4'(a); bus4.B = 4'(b); bus4.SUB = sub; bus4.ACC = accm; bus4.ENTER = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus4.DONE && cyc < 8);
        check({name, "_latency"}, cyc, 3);
        check({name, "_mag"}, int'(bus4.RES_MAG), e_mag);
        check({name, "_neg"}, int'(bus4.RES_NEG), e_neg);
        check({name, "_valid"}, int'(bus4.VALID), e_valid);
        check({name, "_sticky"}, int'(bus4.OVF_STICKY), e_sticky);
        bus4.ENTER = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic op8(string name, int a, int b, int e_mag, int e_neg, int e_valid);
        int cyc;
        bus8.A = 8'(a); bus8.B = 8'(b); bus8.SUB = 1'b0; bus8.ACC = 1'b0; bus8.ENTER = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus8.DONE && cyc < 8);
        check({name, "_latency"}, cyc, 3);
        check({name, "_mag"}, int'(bus8.RES_MAG), e_mag);
        check({name, "_neg"}, int'(bus8.RES_NEG), e_neg);
        check({name, "_valid"}, int'(bus8.VALID), e_valid);
        bus8.ENTER = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int dones;
        int busys;
        total = 0; bad = 0;
        rst = 1'b1;
        bus4.CLR = 1'b0; bus4.ENTER = 1'b0; bus4.SUB = 1'b0; bus4.ACC = 1'b0; bus4.A = 4'd0; bus4.B = 4'd0;
        bus8.CLR = 1'b0; bus8.ENTER = 1'b0; bus8.SUB = 1'b0; bus8.ACC = 1'b0; bus8.A = 8'd0; bus8.B = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_mag", int'(bus4.RES_MAG), 0);
        check("rst_valid", int'(bus4.VALID), 1);
        check("rst_busy", int'(bus4.BUSY), 0);
        rst = 1'b0;
        @(negedge clk);

        op4("add",      3, 4, 1'b0, 1'b0, 7, 0, 1, 0);
        op4("ovf",      7, 1, 1'b0, 1'b0, 7, 0, 0, 1);
        op4("post_ovf", 1, 1, 1'b0, 1'b0, 2, 0, 1, 1);
        op4("sub",      2, 5, 1'b1, 1'b0, 3, 1, 1, 1);
        op4("most_neg", -8, 0, 1'b0, 1'b0, 8, 1, 1, 1);

        bus4.CLR = 1'b1;
        @(negedge clk);
        bus4.CLR = 1'b0;
        check("clr_mag", int'(bus4.RES_MAG), 0);
        check("clr_neg", int'(bus4.RES_NEG), 0);
        check("clr_sticky", int'(bus4.OVF_STICKY), 0);

        op4("acc1",    0, 3, 1'b0, 1'b1, 3, 0, 1, 0);
        op4("acc2",    0, 3, 1'b0, 1'b1, 6, 0, 1, 0);
        op4("acc3",    0, 3, 1'b0, 1'b1, 6, 0, 0, 1);
        op4("acc_sub", 0, 3, 1'b1, 1'b1, 3, 0, 1, 1);

        // Abort: CLR lands while the op sits in EXEC.
        bus4.A = 4'd1; bus4.B = 4'd1; bus4.SUB = 1'b0; bus4.ACC = 1'b0; bus4.ENTER = 1'b1;
        @(negedge clk);
        check("abort_busy_before", int'(bus4.BUSY), 1);
        bus4.CLR = 1'b1;
        @(negedge clk);
        bus4.CLR = 1'b0;
        check("abort_busy_after", int'(bus4.BUSY), 0);
        check("abort_mag", int'(bus4.RES_MAG), 0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus4.DONE) dones++;
        end
        check("abort_no_done", dones, 0);
        bus4.ENTER = 1'b0;
        @(negedge clk);

        op4("pre_rst", 2, 2, 1'b0, 1'b0, 4, 0, 1, 0);
        rst = 1'b1; bus4.ENTER = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_mag", int'(bus4.RES_MAG), 0);
        rst = 1'b0;
        dones = 0; busys = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus4.DONE) dones++;
            if (bus4.BUSY) busys++;
        end
        check("held_enter_done", dones, 0);
        check("held_enter_busy", busys, 0);
        bus4.ENTER = 1'b0;
        @(negedge clk);

        // A second rising edge while the op is in flight must not start another op.
        bus4.A = 4'd1; bus4.B = 4'd2; bus4.SUB = 1'b0; bus4.ACC = 1'b0; bus4.ENTER = 1'b1;
        @(negedge clk);
        bus4.ENTER = 1'b0;
        @(negedge clk);
        bus4.ENTER = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.DONE) dones++;
        end
        check("busy_edge_dones", dones, 1);
        check("busy_edge_mag", int'(bus4.RES_MAG), 3);
        bus4.ENTER = 1'b0;
        repeat (2) @(negedge clk);

        op8("w8_ovf", -128, -1, 0, 0, 0);
        check("w8_ovf_sticky", int'(bus8.OVF_STICKY), 1);
        op8("w8_add", 100, -28, 72, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
